// File: rtl/project_selector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : project_selector_pkg
// Description : Shared definitions for the project selector: register
//               offsets inside the Wishbone window, bit positions of the
//               SEL/STATUS fields, and the switch-sequence FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package project_selector_pkg;

  // Register offsets (low nibble of the Wishbone address)
  localparam logic [3:0] OFF_SEL    = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_GUARD  = 4'h8;

  // Field positions
  localparam int SEL_EN_BIT  = 7;
  localparam int ST_EN_BIT   = 7;
  localparam int ST_BUSY_BIT = 8;
  localparam int ST_ERR_BIT  = 9;
  localparam int ST_PEND_BIT = 10;

  // Switch sequence FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ARM   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/project_selector_wb_regs.sv
`default_nettype none
// ============================================================================
// Module      : project_selector_wb_regs
// Description : Wishbone slave for the project selector. Decodes the 16-byte
//               register window, generates a single-cycle ack, holds the SEL,
//               GUARD and err registers, and returns read data (zero whenever
//               ack is low). A committed SEL write is reported to the FSM as a
//               one-cycle sel_wr pulse aligned with the ack.
// Ports       : clk, rst_n            - clock, async active-low reset
//               stb, cyc, we, be,      - Wishbone request
//               dat_w, adr
//               ack, dat_r             - Wishbone response
//               cur_idx, cur_en, busy, - live status from the FSM
//               pending
//               sel_wr, sel_idx,       - SEL write event and stored selection
//               sel_en
//               guard                  - guard-cycle register
// Revision    : 1.0 - initial release
// ============================================================================
module project_selector_wb_regs
  import project_selector_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NUM_PROJ  = 8,
  parameter int          GUARD_RST = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        cyc,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] dat_w,
  input  logic [31:0] adr,
  output logic        ack,
  output logic [31:0] dat_r,
  input  logic [3:0]  cur_idx,
  input  logic        cur_en,
  input  logic        busy,
  input  logic        pending,
  output logic        sel_wr,
  output logic [3:0]  sel_idx,
  output logic        sel_en,
  output logic [15:0] guard
);

  logic        ack_q;
  logic [31:0] dat_q;
  logic        sel_wr_q;
  logic [3:0]  sel_idx_q;
  logic        sel_en_q;
  logic        err_q;
  logic [15:0] guard_q;

  logic        hit;
  logic        take;
  logic        wr_in_range;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign hit  = stb & cyc & (adr[31:4] == BASE_ADDR[31:4]);
  // A strobe still high during its own ack cycle is the same transfer.
  assign take = hit & ~ack_q;

  assign wr_in_range = ({1'b0, dat_w[3:0]} < 5'(NUM_PROJ));
  assign unused_bits = ^{dat_w[31:16], dat_w[6:4], be[3:2]};

  always_comb begin
    rd_mux = '0;
    case (adr[3:0])
      OFF_SEL: begin
        rd_mux[3:0]       = sel_idx_q;
        rd_mux[SEL_EN_BIT] = sel_en_q;
      end
      OFF_STATUS: begin
        rd_mux[3:0]        = cur_idx;
        rd_mux[ST_EN_BIT]   = cur_en;
        rd_mux[ST_BUSY_BIT] = busy;
        rd_mux[ST_ERR_BIT]  = err_q;
        rd_mux[ST_PEND_BIT] = pending;
      end
      OFF_GUARD: rd_mux[15:0] = guard_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      sel_wr_q  <= 1'b0;
      sel_idx_q <= '0;
      sel_en_q  <= 1'b0;
      err_q     <= 1'b0;
      guard_q   <= 16'(GUARD_RST);
    end else begin
      ack_q    <= take;
      dat_q    <= (take & ~we) ? rd_mux : '0;
      sel_wr_q <= 1'b0;
      if (take & we) begin
        case (adr[3:0])
          OFF_SEL: begin
            if (be[0]) begin
              // Out-of-range index is stored but forced disabled.
              sel_idx_q <= dat_w[3:0];
              sel_en_q  <= dat_w[SEL_EN_BIT] & wr_in_range;
              err_q     <= ~wr_in_range;
              sel_wr_q  <= 1'b1;
            end
          end
          OFF_GUARD: begin
            if (be[0]) guard_q[7:0]  <= dat_w[7:0];
            if (be[1]) guard_q[15:8] <= dat_w[15:8];
          end
          default: ;
        endcase
      end
    end
  end

  assign ack     = ack_q;
  assign dat_r   = dat_q;
  assign sel_wr  = sel_wr_q;
  assign sel_idx = sel_idx_q;
  assign sel_en  = sel_en_q;
  assign guard   = guard_q;

endmodule
`default_nettype wire

// File: rtl/project_selector.sv
`default_nettype none
// ============================================================================
// Module      : project_selector
// Description : Wishbone-controlled one-hot project enable. A change of
//               selection runs IDLE -> DRAIN (all outputs off for
//               max(GUARD,1) cycles) -> ARM (one cycle) -> IDLE with the new
//               one-hot enable. SEL writes during a sequence land in a
//               single-deep pending slot (last write wins).
//               Optional macro PROJECT_SELECTOR_IRQ_EN: when defined, irq_o
//               pulses for one cycle on each ARM->IDLE transition; otherwise
//               irq_o is tied low.
// Ports       : wb_clk_i, wb_rst_ni    - clock, async active-low reset
//               wbs_*                  - Wishbone slave
//               active_o[NUM_PROJ]     - one-hot project enables
//               busy_o                 - switch sequence in progress
//               irq_o                  - switch-complete pulse
// Revision    : 1.0 - initial release
// ============================================================================
module project_selector
  import project_selector_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NUM_PROJ  = 8,
  parameter int          GUARD_RST = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_dat_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic [NUM_PROJ-1:0] active_o,
  output logic                busy_o,
  output logic                irq_o
);

  logic        sel_wr;
  logic [3:0]  sel_idx;
  logic        sel_en;
  logic [15:0] guard;
  logic [15:0] guard_len;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  tgt_idx_q, tgt_idx_d;
  logic        tgt_en_q, tgt_en_d;
  logic        pend_q, pend_d;
  logic [3:0]  pend_idx_q, pend_idx_d;
  logic        pend_en_q, pend_en_d;
  logic [3:0]  cur_idx_q, cur_idx_d;
  logic        cur_en_q, cur_en_d;

  project_selector_wb_regs #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_PROJ  (NUM_PROJ),
    .GUARD_RST (GUARD_RST)
  ) u_regs (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .stb     (wbs_stb_i),
    .cyc     (wbs_cyc_i),
    .we      (wbs_we_i),
    .be      (wbs_sel_i),
    .dat_w   (wbs_dat_i),
    .adr     (wbs_adr_i),
    .ack     (wbs_ack_o),
    .dat_r   (wbs_dat_o),
    .cur_idx (cur_idx_q),
    .cur_en  (cur_en_q),
    .busy    (busy_o),
    .pending (pend_q),
    .sel_wr  (sel_wr),
    .sel_idx (sel_idx),
    .sel_en  (sel_en),
    .guard   (guard)
  );

  // A zero guard still drains for one cycle.
  assign guard_len = (guard == 16'd0) ? 16'd1 : guard;
  assign busy_o    = (state_q != ST_IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tgt_idx_q  <= '0;
      tgt_en_q   <= 1'b0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      pend_en_q  <= 1'b0;
      cur_idx_q  <= '0;
      cur_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_idx_q  <= tgt_idx_d;
      tgt_en_q   <= tgt_en_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      pend_en_q  <= pend_en_d;
      cur_idx_q  <= cur_idx_d;
      cur_en_q   <= cur_en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_idx_d  = tgt_idx_q;
    tgt_en_d   = tgt_en_q;
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;
    pend_en_d  = pend_en_q;
    cur_idx_d  = cur_idx_q;
    cur_en_d   = cur_en_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_wr && ({sel_idx, sel_en} != {cur_idx_q, cur_en_q})) begin
          state_d   = ST_DRAIN;
          tgt_idx_d = sel_idx;
          tgt_en_d  = sel_en;
          cnt_d     = guard_len;   // guard is captured once per sequence
        end
      end
      ST_DRAIN: begin
        if (sel_wr) begin
          pend_d     = 1'b1;
          pend_idx_d = sel_idx;
          pend_en_d  = sel_en;
        end
        if (cnt_q <= 16'd1) state_d = ST_ARM;
        else                cnt_d   = cnt_q - 16'd1;
      end
      ST_ARM: begin
        cur_idx_d = tgt_idx_q;
        cur_en_d  = tgt_en_q;
        // A write landing in the ARM cycle itself is the newest pending value.
        if (pend_q || sel_wr) begin
          state_d   = ST_DRAIN;
          tgt_idx_d = sel_wr ? sel_idx : pend_idx_q;
          tgt_en_d  = sel_wr ? sel_en  : pend_en_q;
          pend_d    = 1'b0;
          cnt_d     = guard_len;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Comparator per bit: at most one bit can ever match the index.
  always_comb begin
    active_o = '0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      active_o[i] = (state_q == ST_IDLE) && cur_en_q && (cur_idx_q == 4'(i));
    end
  end

`ifdef PROJECT_SELECTOR_IRQ_EN
  logic irq_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) irq_q <= 1'b0;
    else            irq_q <= (state_q == ST_ARM) && (state_d == ST_IDLE);
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule
`default_nettype wire
